// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and the memory.
// The master (pipeline stage) holds req/we/addr/wdata steady until ack.
interface mem_stage_if #(
    parameter int ADDR_W = 16
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: forwards ALU results in one cycle, performs LDW/STW over a
// req/ack data-memory bus, stalls upstream while waiting, and aborts on timeout.
module mem_stage #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_2_mem,
    input  logic [31:0] rd_2_mem,
    input  logic [31:0] A_2_mem,
    input  logic [31:0] st_data_2_mem,
    input  logic        mem_read_2_mem,
    input  logic        mem_write_2_mem,
    input  logic        mem_to_reg_2_mem,
    input  logic        reg_write_2_mem,
    input  logic [4:0]  rd_add_value_2_mem,
    mem_stage_if.master dmem,
    output logic        stall_out,
    output logic        valid_2_wb,
    output logic [31:0] wb_data_2_wb,
    output logic        reg_write_2_wb,
    output logic [4:0]  rd_add_value_2_wb,
    output logic [1:0]  err_flags
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_alu;
    logic              r_m2r;
    logic              r_regw;
    logic [4:0]        r_rd_add;

    logic              r_valid_wb;
    logic [31:0]       r_wb_data;
    logic              r_regw_wb;
    logic [4:0]        r_rd_add_wb;
    logic [1:0]        r_err;

    logic              w_is_mem;
    logic              w_capture;
    logic              w_alu_pass;
    logic              w_ack_done;
    logic              w_timeout;
    logic              w_unused_addr_hi;

    assign w_is_mem         = mem_read_2_mem | mem_write_2_mem;
    // Upper address bits are outside the word-address window of the memory.
    assign w_unused_addr_hi = ^A_2_mem;

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode plus the per-cycle event strobes used by the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_alu_pass  = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_2_mem && w_is_mem) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (valid_2_mem) begin
                    w_alu_pass  = 1'b1;
                end
            end
            S_WAIT: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (dmem.dmem_ack) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, wait counter, write-back registers and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_alu       <= '0;
            r_m2r       <= 1'b0;
            r_regw      <= 1'b0;
            r_rd_add    <= '0;
            r_valid_wb  <= 1'b0;
            r_wb_data   <= '0;
            r_regw_wb   <= 1'b0;
            r_rd_add_wb <= '0;
            r_err       <= '0;
        end else begin
            r_valid_wb <= 1'b0;
            if (w_alu_pass) begin
                r_valid_wb  <= 1'b1;
                r_wb_data   <= rd_2_mem;
                r_regw_wb   <= reg_write_2_mem;
                r_rd_add_wb <= rd_add_value_2_mem;
            end
            if (w_capture) begin
                r_cnt    <= '0;
                r_req    <= 1'b1;
                // A simultaneous read+write is issued as a read and flagged.
                r_we     <= mem_write_2_mem & ~mem_read_2_mem;
                r_addr   <= A_2_mem[ADDR_W-1:0];
                r_wdata  <= st_data_2_mem;
                r_alu    <= rd_2_mem;
                r_m2r    <= mem_to_reg_2_mem;
                r_regw   <= reg_write_2_mem;
                r_rd_add <= rd_add_value_2_mem;
                if (mem_read_2_mem && mem_write_2_mem) r_err[1] <= 1'b1;
            end
            if (w_ack_done) begin
                r_req       <= 1'b0;
                r_valid_wb  <= 1'b1;
                r_wb_data   <= (!r_we && r_m2r) ? dmem.dmem_rdata : r_alu;
                r_regw_wb   <= r_we ? 1'b0 : r_regw;
                r_rd_add_wb <= r_rd_add;
            end else if (w_timeout) begin
                r_req       <= 1'b0;
                r_valid_wb  <= 1'b1;
                r_wb_data   <= '0;
                r_regw_wb   <= 1'b0;
                r_rd_add_wb <= r_rd_add;
                r_err[0]    <= 1'b1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stall_out         = (r_state == S_WAIT);
    assign dmem.dmem_req     = r_req;
    assign dmem.dmem_we      = r_we;
    assign dmem.dmem_addr    = r_addr;
    assign dmem.dmem_wdata   = r_wdata;
    assign valid_2_wb        = r_valid_wb;
    assign wb_data_2_wb      = r_wb_data;
    assign reg_write_2_wb    = r_regw_wb;
    assign rd_add_value_2_wb = r_rd_add_wb;
    assign err_flags         = r_err;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short timeout so the abort path is reachable.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_2_mem = 1'b0;
    logic [31:0] rd_2_mem = '0;
    logic [31:0] A_2_mem = '0;
    logic [31:0] st_data_2_mem = '0;
    logic        mem_read_2_mem = 1'b0;
    logic        mem_write_2_mem = 1'b0;
    logic        mem_to_reg_2_mem = 1'b0;
    logic        reg_write_2_mem = 1'b0;
    logic [4:0]  rd_add_value_2_mem = '0;
    logic        stall_out;
    logic        valid_2_wb;
    logic [31:0] wb_data_2_wb;
    logic        reg_write_2_wb;
    logic [4:0]  rd_add_value_2_wb;
    logic [1:0]  err_flags;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_if #(.ADDR_W(16)) dmem_bus ();

    mem_stage #(.ADDR_W(16), .TIMEOUT_CYC(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .valid_2_mem        (valid_2_mem),
        .rd_2_mem           (rd_2_mem),
        .A_2_mem            (A_2_mem),
        .st_data_2_mem      (st_data_2_mem),
        .mem_read_2_mem     (mem_read_2_mem),
        .mem_write_2_mem    (mem_write_2_mem),
        .mem_to_reg_2_mem   (mem_to_reg_2_mem),
        .reg_write_2_mem    (reg_write_2_mem),
        .rd_add_value_2_mem (rd_add_value_2_mem),
        .dmem               (dmem_bus),
        .stall_out          (stall_out),
        .valid_2_wb         (valid_2_wb),
        .wb_data_2_wb       (wb_data_2_wb),
        .reg_write_2_wb     (reg_write_2_wb),
        .rd_add_value_2_wb  (rd_add_value_2_wb),
        .err_flags          (err_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic m2r,
                          input logic rw, input logic [31:0] alu, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] dst);
        valid_2_mem        = v;
        mem_read_2_mem     = rd;
        mem_write_2_mem    = wr;
        mem_to_reg_2_mem   = m2r;
        reg_write_2_mem    = rw;
        rd_2_mem           = alu;
        A_2_mem            = a;
        st_data_2_mem      = sd;
        rd_add_value_2_mem = dst;
    endtask

    initial begin
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_valid", valid_2_wb, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_req", dmem_bus.dmem_req, 0);
        chk("rst_err", err_flags, 0);
        chk("rst_wbdata", wb_data_2_wb, 0);
        reset = 1'b1;
        tick();

        // 1: ALU op, one-cycle latency, no stall
        set_op(1, 0, 0, 0, 1, 32'h7, 32'h0, 32'h0, 5'd5);
        tick();
        chk("alu_valid", valid_2_wb, 1);
        chk("alu_data", wb_data_2_wb, 32'h7);
        chk("alu_rdadd", rd_add_value_2_wb, 5);
        chk("alu_regw", reg_write_2_wb, 1);
        chk("alu_stall", stall_out, 0);
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("alu_pulse", valid_2_wb, 0);
        chk("alu_hold", wb_data_2_wb, 32'h7);

        // ack while idle is ignored
        dmem_bus.dmem_ack = 1'b1;
        tick();
        chk("idle_ack_valid", valid_2_wb, 0);
        chk("idle_ack_stall", stall_out, 0);
        dmem_bus.dmem_ack = 1'b0;

        // 2: LDW, ack sampled on the third WAIT edge
        set_op(1, 1, 0, 1, 1, 32'h55, 32'h10, 32'h0, 5'd9);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("ld_req", dmem_bus.dmem_req, 1);
        chk("ld_we", dmem_bus.dmem_we, 0);
        chk("ld_addr", dmem_bus.dmem_addr, 32'h10);
        chk("ld_stall1", stall_out, 1);
        chk("ld_valid_cap", valid_2_wb, 0);
        tick();
        chk("ld_stall2", stall_out, 1);
        tick();
        chk("ld_stall3", stall_out, 1);
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        chk("ld_stall_end", stall_out, 0);
        chk("ld_req_end", dmem_bus.dmem_req, 0);
        chk("ld_valid", valid_2_wb, 1);
        chk("ld_data", wb_data_2_wb, 32'hCAFE_F00D);
        chk("ld_regw", reg_write_2_wb, 1);
        chk("ld_rdadd", rd_add_value_2_wb, 9);

        // 3: STW, ack on first WAIT edge
        set_op(1, 0, 1, 0, 1, 32'hAA, 32'h4, 32'h1234, 5'd3);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("st_req", dmem_bus.dmem_req, 1);
        chk("st_we", dmem_bus.dmem_we, 1);
        chk("st_addr", dmem_bus.dmem_addr, 32'h4);
        chk("st_wdata", dmem_bus.dmem_wdata, 32'h1234);
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        chk("st_req_end", dmem_bus.dmem_req, 0);
        chk("st_valid", valid_2_wb, 1);
        chk("st_regw", reg_write_2_wb, 0);
        chk("st_data", wb_data_2_wb, 32'hAA);

        // 4: LDW with no ack, timeout after 4 WAIT cycles
        set_op(1, 1, 0, 1, 1, 32'h66, 32'h20, 32'h0, 5'd7);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("to_req0", dmem_bus.dmem_req, 1);
        tick();
        tick();
        tick();
        chk("to_req3", dmem_bus.dmem_req, 1);
        chk("to_err_pre", err_flags, 0);
        tick();
        chk("to_req_end", dmem_bus.dmem_req, 0);
        chk("to_stall_end", stall_out, 0);
        chk("to_valid", valid_2_wb, 1);
        chk("to_data", wb_data_2_wb, 0);
        chk("to_regw", reg_write_2_wb, 0);
        chk("to_err", err_flags, 2'b01);
        set_op(1, 0, 0, 0, 1, 32'h33, 32'h0, 32'h0, 5'd1);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("to_err_sticky", err_flags, 2'b01);
        chk("to_next_alu", wb_data_2_wb, 32'h33);
        reset = 1'b0;
        #1;
        chk("to_err_clr", err_flags, 0);
        tick();
        reset = 1'b1;
        tick();

        // 5a: read and write both set -> read with illegal-op flag
        set_op(1, 1, 1, 1, 1, 32'h0, 32'h8, 32'hFFFF, 5'd2);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("ill_req", dmem_bus.dmem_req, 1);
        chk("ill_we", dmem_bus.dmem_we, 0);
        chk("ill_err", err_flags, 2'b10);
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h11;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        chk("ill_data", wb_data_2_wb, 32'h11);
        chk("ill_regw", reg_write_2_wb, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 5b: ack on the timeout edge wins
        set_op(1, 1, 0, 1, 1, 32'h0, 32'h30, 32'h0, 5'd6);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        tick();
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hBEEF;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        chk("race_valid", valid_2_wb, 1);
        chk("race_data", wb_data_2_wb, 32'hBEEF);
        chk("race_err", err_flags, 0);

        // 6: reset mid-WAIT, then normal ALU op
        set_op(1, 1, 0, 1, 1, 32'h0, 32'h40, 32'h0, 5'd8);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("mid_stall", stall_out, 1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_req_drop", dmem_bus.dmem_req, 0);
        chk("mid_stall_drop", stall_out, 0);
        chk("mid_valid", valid_2_wb, 0);
        tick();
        chk("mid_valid_hold", valid_2_wb, 0);
        #2;
        reset = 1'b1;
        tick();
        set_op(1, 0, 0, 0, 1, 32'h99, 32'h0, 32'h0, 5'd4);
        tick();
        set_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("post_valid", valid_2_wb, 1);
        chk("post_data", wb_data_2_wb, 32'h99);
        chk("post_rdadd", rd_add_value_2_wb, 4);
        chk("post_stall", stall_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
